// File: rtl/rps_match_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rps_match_ctrl_if
//  Description : Throw handshake, mode select, score and result bundle
//                between the match controller and its surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rps_match_ctrl_if;
    logic       tick;
    logic       start;
    logic       ext_mode;
    logic [2:0] compu_ext;
    logic [2:0] user;
    logic       throw_valid;
    logic       throw_ready;
    logic [2:0] compu;
    logic [1:0] winornot;
    logic [2:0] puser;
    logic [2:0] pcompu;
    logic       match_done;
    logic [1:0] match_winner;
    logic       err;

    // Driver side: switches, divider tick and start button
    modport master (
        output tick, start, ext_mode, compu_ext, user, throw_valid,
        input  throw_ready, compu, winornot, puser, pcompu,
               match_done, match_winner, err
    );

    // Controller side
    modport slave (
        input  tick, start, ext_mode, compu_ext, user, throw_valid,
        output throw_ready, compu, winornot, puser, pcompu,
               match_done, match_winner, err
    );
endinterface
`default_nettype wire

// File: rtl/rps_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rps_match_ctrl
//  Description : Rock-paper-scissors match controller. Accepts one user throw
//                per round, picks the computer throw (LFSR or second player),
//                judges, keeps scores and declares the match winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rps_match_ctrl #(
    parameter int         WIN_TARGET   = 3,
    parameter int         REVEAL_TICKS = 4,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  wire logic       CLK,
    input  wire logic       RST_N,
    rps_match_ctrl_if.slave bus
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_WAIT_THROW = 2'd1;
    localparam logic [1:0] c_REVEAL     = 2'd2;
    localparam logic [1:0] c_DONE       = 2'd3;

    localparam logic [2:0] c_WIN       = 3'(WIN_TARGET);
    localparam logic [3:0] c_TICK_LAST = 4'(REVEAL_TICKS - 1);

    localparam logic [1:0] c_RES_TIE   = 2'b00;
    localparam logic [1:0] c_RES_COMPU = 2'b01;
    localparam logic [1:0] c_RES_USER  = 2'b10;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_compu;
    logic [1:0] r_winornot;
    logic [2:0] r_puser;
    logic [2:0] r_pcompu;
    logic [1:0] r_match_winner;
    logic       r_err;

    logic       w_throw_ready;
    logic       w_match_done;
    logic       w_user_oh;
    logic       w_ext_oh;
    logic       w_throw_ok;
    logic       w_handshake;
    logic       w_accept;
    logic       w_reject;
    logic       w_reveal_last;
    logic       w_target_hit;
    logic [2:0] w_lfsr_throw;
    logic [2:0] w_compu_throw;
    logic [1:0] w_result;

    function automatic logic f_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // A throw is only legal when every side of it is a single switch
    assign w_user_oh   = f_onehot3(bus.user);
    assign w_ext_oh    = f_onehot3(bus.compu_ext);
    assign w_throw_ok  = w_user_oh && (!bus.ext_mode || w_ext_oh);
    assign w_handshake = bus.throw_valid && w_throw_ready;
    // start wins over the handshake: the throw is silently dropped
    assign w_accept    = w_handshake && w_throw_ok && !bus.start;
    assign w_reject    = w_handshake && !w_throw_ok && !bus.start;

    assign w_target_hit  = (r_puser == c_WIN) || (r_pcompu == c_WIN);
    assign w_reveal_last = (r_state == c_REVEAL) && bus.tick &&
                           (r_tick_cnt == c_TICK_LAST);

    // Taps for x^8+x^6+x^5+x^4+1, shifting towards the MSB
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Map the LFSR residue mod 3 onto a one-hot computer throw
    always_comb begin
        w_lfsr_throw = 3'b100;
        case (r_lfsr % 8'd3)
            8'd0:    w_lfsr_throw = 3'b001;
            8'd1:    w_lfsr_throw = 3'b010;
            default: w_lfsr_throw = 3'b100;
        endcase
    end

    assign w_compu_throw = bus.ext_mode ? bus.compu_ext : w_lfsr_throw;

    // Round verdict; only consumed when both throws are one-hot
    always_comb begin
        w_result = c_RES_TIE;
        if (w_compu_throw != bus.user) begin
            case ({w_compu_throw, bus.user})
                6'b010_100, 6'b001_010, 6'b100_001: w_result = c_RES_COMPU;
                default:                            w_result = c_RES_USER;
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= c_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (bus.start) begin
            w_state_next = c_WAIT_THROW;
        end else begin
            case (r_state)
                c_IDLE:       w_state_next = c_IDLE;
                c_WAIT_THROW: if (w_accept) w_state_next = c_REVEAL;
                c_REVEAL:     if (w_reveal_last)
                                  w_state_next = w_target_hit ? c_DONE : c_WAIT_THROW;
                c_DONE:       w_state_next = c_DONE;
                default:      w_state_next = c_IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        w_throw_ready = (r_state == c_WAIT_THROW);
        w_match_done  = (r_state == c_DONE);
    end

    // Free-running LFSR, advances every cycle in every state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end

    // Reveal hold counter; a tick in the accept cycle is not seen here
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_tick_cnt <= '0;
        else if (bus.start || (r_state != c_REVEAL))
            r_tick_cnt <= '0;
        else if (bus.tick)
            r_tick_cnt <= (r_tick_cnt == c_TICK_LAST) ? 4'd0 : r_tick_cnt + 4'd1;
    end

    // Round result, scores and match winner
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_compu        <= '0;
            r_winornot     <= c_RES_TIE;
            r_puser        <= '0;
            r_pcompu       <= '0;
            r_match_winner <= 2'b00;
        end else if (bus.start) begin
            r_compu        <= '0;
            r_winornot     <= c_RES_TIE;
            r_puser        <= '0;
            r_pcompu       <= '0;
            r_match_winner <= 2'b00;
        end else if (w_accept) begin
            r_compu    <= w_compu_throw;
            r_winornot <= w_result;
            if (w_result == c_RES_USER)  r_puser  <= r_puser + 3'd1;
            if (w_result == c_RES_COMPU) r_pcompu <= r_pcompu + 3'd1;
        end else if (w_reveal_last && w_target_hit) begin
            r_match_winner <= (r_puser == c_WIN) ? c_RES_USER : c_RES_COMPU;
        end
    end

    // One-cycle error pulse after a rejected handshake
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_err <= 1'b0;
        else        r_err <= w_reject;
    end

    assign bus.throw_ready  = w_throw_ready;
    assign bus.match_done   = w_match_done;
    assign bus.compu        = r_compu;
    assign bus.winornot     = r_winornot;
    assign bus.puser        = r_puser;
    assign bus.pcompu       = r_pcompu;
    assign bus.match_winner = r_match_winner;
    assign bus.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rps_match_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rps_match_ctrl
//  Description : Self-checking bench for rps_match_ctrl. DUT A plays full
//                matches (target 3, 4-tick reveal); DUT B walks the judging
//                table (target 7, 1-tick reveal).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rps_match_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rps_match_ctrl_if aif ();
    rps_match_ctrl_if bif ();

    rps_match_ctrl #(.WIN_TARGET(3), .REVEAL_TICKS(4), .LFSR_SEED(8'hA5)) dut_a (
        .CLK(clk), .RST_N(rst_n), .bus(aif));
    rps_match_ctrl #(.WIN_TARGET(7), .REVEAL_TICKS(1), .LFSR_SEED(8'hA5)) dut_b (
        .CLK(clk), .RST_N(rst_n), .bus(bif));

    int checks = 0;
    int errors = 0;

    // Reference model state for DUT A
    int         m_pu;
    int         m_pc;
    logic [2:0] m_compu;
    logic [1:0] m_res;
    logic [7:0] m_lfsr;

    logic [15:0] a_outs;
    logic [15:0] b_outs;
    assign a_outs = {aif.throw_ready, aif.compu, aif.winornot, aif.puser, aif.pcompu,
                     aif.match_done, aif.match_winner, aif.err};
    assign b_outs = {bif.throw_ready, bif.compu, bif.winornot, bif.puser, bif.pcompu,
                     bif.match_done, bif.match_winner, bif.err};

    // Reference LFSR sequence x^8+x^6+x^5+x^4+1 from the seed
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic int idx(input logic [2:0] t);
        return (t == 3'b001) ? 0 : (t == 3'b010) ? 1 : 2;
    endfunction

    function automatic logic [2:0] throw_of(input int i);
        logic [2:0] t;
        t = 3'b001 << i;
        return t;
    endfunction

    // Cyclic rule: the throw one step "above" the other wins
    function automatic logic [1:0] judge(input logic [2:0] u, input logic [2:0] c);
        int d;
        d = (idx(u) - idx(c) + 3) % 3;
        if (d == 0) return 2'b00;
        return (d == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [15:0] exp_vec(input logic rdy, input logic done,
                                            input logic [1:0] win, input logic e);
        return {rdy, m_compu, m_res, 3'(m_pu), 3'(m_pc), done, win, e};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start_a();
        aif.start = 1'b1;
        step();
        aif.start = 1'b0;
        m_pu = 0; m_pc = 0; m_compu = 3'b000; m_res = 2'b00;
        checks++;
        if (a_outs !== exp_vec(1'b1, 1'b0, 2'b00, 1'b0)) begin
            errors++;
            $display("FAIL start_clear: got %h want %h", a_outs, exp_vec(1'b1, 1'b0, 2'b00, 1'b0));
        end
    endtask

    // One full round on DUT A with tick pulses every 'gap' cycles
    task automatic play_round_a(input logic [2:0] u, input logic ext,
                                input logic [2:0] cext, input int gap);
        logic [15:0] e;
        logic        done;
        logic [1:0]  win;
        checks++;
        if (aif.throw_ready !== 1'b1) begin
            errors++;
            $display("FAIL round_ready: got %b want 1", aif.throw_ready);
        end
        m_compu = ext ? cext : throw_of(int'(m_lfsr % 8'd3));
        m_res   = judge(u, m_compu);
        aif.user = u; aif.ext_mode = ext; aif.compu_ext = cext;
        aif.throw_valid = 1'b1;
        aif.tick = 1'b1;
        step();
        aif.throw_valid = 1'b0;
        aif.tick = 1'b0;
        aif.ext_mode = 1'($urandom);
        if (m_res == 2'b10) m_pu++;
        if (m_res == 2'b01) m_pc++;
        e = exp_vec(1'b0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (a_outs !== e) begin
            errors++;
            $display("FAIL round_accept: got %h want %h", a_outs, e);
        end
        done = (m_pu == 3) || (m_pc == 3);
        win  = !done ? 2'b00 : (m_pu == 3) ? 2'b10 : 2'b01;
        for (int t = 0; t < 4; t++) begin
            repeat (gap - 1) begin
                step();
                checks++;
                if (a_outs !== e) begin
                    errors++;
                    $display("FAIL reveal_hold: got %h want %h", a_outs, e);
                end
            end
            aif.tick = 1'b1;
            step();
            aif.tick = 1'b0;
            if (t == 3) e = exp_vec(!done, done, win, 1'b0);
            checks++;
            if (a_outs !== e) begin
                errors++;
                $display("FAIL reveal_tick%0d: got %h want %h", t, a_outs, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++;
        if (a_outs !== 16'h0000) begin
            errors++; $display("FAIL reset_a: got %h want 0000", a_outs);
        end
        checks++;
        if (b_outs !== 16'h0000) begin
            errors++; $display("FAIL reset_b: got %h want 0000", b_outs);
        end
        rst_n = 1'b1;
        step(2);
        checks++;
        if (a_outs !== 16'h0000) begin
            errors++; $display("FAIL idle_hold: got %h want 0000", a_outs);
        end
        bif.start = 1'b1;
        do_start_a();
        bif.start = 1'b0;
        checks++;
        if (b_outs !== 16'h8000) begin
            errors++; $display("FAIL start_b: got %h want 8000", b_outs);
        end
    endtask

    task automatic test_judging();
        int order [9];
        int pu, pc, j, tmp;
        logic [2:0] u, c;
        logic [1:0] r;
        pu = 0; pc = 0;
        for (int i = 0; i < 9; i++) order[i] = i;
        for (int i = 8; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        bif.ext_mode = 1'b1;
        for (int k = 0; k < 9; k++) begin
            u = throw_of(order[k] / 3);
            c = throw_of(order[k] % 3);
            r = judge(u, c);
            checks++;
            if (bif.throw_ready !== 1'b1) begin
                errors++; $display("FAIL judge_ready: got %b want 1", bif.throw_ready);
            end
            bif.user = u; bif.compu_ext = c; bif.throw_valid = 1'b1;
            step();
            bif.throw_valid = 1'b0;
            if (r == 2'b10) pu++;
            if (r == 2'b01) pc++;
            checks++;
            if ({bif.compu, bif.winornot, bif.puser, bif.pcompu, bif.throw_ready} !==
                {c, r, 3'(pu), 3'(pc), 1'b0}) begin
                errors++;
                $display("FAIL judge u=%b c=%b: got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         u, c, bif.compu, bif.winornot, bif.puser, bif.pcompu, c, r, pu, pc);
            end
            step();
        end
        checks++;
        if ({bif.puser, bif.pcompu, bif.match_done, bif.throw_ready} !== {3'd3, 3'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL judge_final: got %0d/%0d done=%b rdy=%b want 3/3 done=0 rdy=1",
                     bif.puser, bif.pcompu, bif.match_done, bif.throw_ready);
        end
    endtask

    task automatic test_reveal_pacing();
        do_start_a();
        play_round_a(throw_of(int'($urandom_range(2, 0))), 1'b0, 3'b000, 10);
    endtask

    task automatic test_match_end();
        logic [15:0] e;
        do_start_a();
        for (int i = 0; i < 3; i++)
            play_round_a(3'b010, 1'b1, 3'b100, int'($urandom_range(3, 1)));
        e = exp_vec(1'b0, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            aif.user = 3'b010; aif.ext_mode = 1'b1; aif.compu_ext = 3'b100;
            aif.throw_valid = 1'b1; aif.tick = 1'($urandom);
            step();
            checks++;
            if (a_outs !== e) begin
                errors++; $display("FAIL done_hold: got %h want %h", a_outs, e);
            end
        end
        aif.throw_valid = 1'b0; aif.tick = 1'b0;
    endtask

    task automatic reject_once(input logic [2:0] u, input logic ext, input logic [2:0] cext);
        aif.user = u; aif.ext_mode = ext; aif.compu_ext = cext; aif.throw_valid = 1'b1;
        step();
        aif.throw_valid = 1'b0;
        checks++;
        if (a_outs !== exp_vec(1'b1, 1'b0, 2'b00, 1'b1)) begin
            errors++;
            $display("FAIL reject_err u=%b: got %h want %h", u, a_outs, exp_vec(1'b1, 1'b0, 2'b00, 1'b1));
        end
        step();
        checks++;
        if (a_outs !== exp_vec(1'b1, 1'b0, 2'b00, 1'b0)) begin
            errors++;
            $display("FAIL reject_clear u=%b: got %h want %h", u, a_outs, exp_vec(1'b1, 1'b0, 2'b00, 1'b0));
        end
    endtask

    task automatic test_reject();
        do_start_a();
        play_round_a(3'b001, 1'b1, 3'b100, 1);
        reject_once(3'b011, 1'b0, 3'b001);
        reject_once(3'b000, 1'b0, 3'b001);
        reject_once(3'b111, 1'b1, 3'b010);
        reject_once(3'b100, 1'b1, 3'b110);
        reject_once(3'b010, 1'b1, 3'b000);
    endtask

    task automatic test_random();
        logic [2:0] bad;
        do_start_a();
        for (int r = 0; r < 20; r++) begin
            if ((m_pu == 3) || (m_pc == 3)) break;
            if ($urandom_range(3, 0) == 0) begin
                bad = 3'($urandom_range(7, 0));
                if ((bad == 3'b001) || (bad == 3'b010) || (bad == 3'b100)) bad = 3'b101;
                reject_once(bad, 1'b0, 3'b000);
            end
            play_round_a(throw_of(int'($urandom_range(2, 0))), 1'($urandom),
                         throw_of(int'($urandom_range(2, 0))), int'($urandom_range(3, 1)));
        end
    endtask

    task automatic test_priority();
        do_start_a();
        play_round_a(3'b010, 1'b1, 3'b100, 1);
        aif.start = 1'b1;
        aif.user = 3'b001; aif.ext_mode = 1'b1; aif.compu_ext = 3'b100; aif.throw_valid = 1'b1;
        step();
        aif.start = 1'b0;
        m_pu = 0; m_pc = 0; m_compu = 3'b000; m_res = 2'b00;
        checks++;
        if (a_outs !== exp_vec(1'b1, 1'b0, 2'b00, 1'b0)) begin
            errors++; $display("FAIL prio_drop: got %h want %h", a_outs, exp_vec(1'b1, 1'b0, 2'b00, 1'b0));
        end
        aif.throw_valid = 1'b0;
        step();
        checks++;
        if (a_outs !== exp_vec(1'b1, 1'b0, 2'b00, 1'b0)) begin
            errors++; $display("FAIL prio_noerr: got %h want %h", a_outs, exp_vec(1'b1, 1'b0, 2'b00, 1'b0));
        end
        // start in the middle of a reveal
        aif.throw_valid = 1'b1;
        step();
        aif.throw_valid = 1'b0;
        aif.start = 1'b1;
        step();
        aif.start = 1'b0;
        checks++;
        if (a_outs !== exp_vec(1'b1, 1'b0, 2'b00, 1'b0)) begin
            errors++; $display("FAIL start_in_reveal: got %h want %h", a_outs, exp_vec(1'b1, 1'b0, 2'b00, 1'b0));
        end
    endtask

    task automatic test_async_reset();
        do_start_a();
        play_round_a(3'b100, 1'b1, 3'b010, 1);
        aif.user = 3'b001; aif.ext_mode = 1'b1; aif.compu_ext = 3'b100; aif.throw_valid = 1'b1;
        step();
        aif.throw_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_outs !== 16'h0000) begin
            errors++; $display("FAIL async_reset: got %h want 0000", a_outs);
        end
        step(2);
        rst_n = 1'b1;
        do_start_a();
        play_round_a(throw_of(int'($urandom_range(2, 0))), 1'b0, 3'b000, 2);
    endtask

    initial begin
        rst_n = 1'b0;
        aif.tick = 1'b0; aif.start = 1'b0; aif.ext_mode = 1'b0; aif.compu_ext = 3'b000;
        aif.user = 3'b000; aif.throw_valid = 1'b0;
        bif.tick = 1'b1; bif.start = 1'b0; bif.ext_mode = 1'b1; bif.compu_ext = 3'b000;
        bif.user = 3'b000; bif.throw_valid = 1'b0;
        m_pu = 0; m_pc = 0; m_compu = 3'b000; m_res = 2'b00;
        test_reset();
        test_judging();
        test_reveal_pacing();
        test_match_end();
        test_reject();
        test_random();
        test_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
